// File: rtl/sl_vphase_gen.sv
// Vertical scanline phase generator: per-output-line position inside the
// source line, plus the video stream delayed to stay aligned with it.
module sl_vphase_gen #(
    localparam int color_width_o = 8
) (
    input  logic                       VCLK_i,
    input  logic                       nVRST_i,
    input  logic                       HSYNC_i,
    input  logic                       VSYNC_i,
    input  logic                       DE_i,
    input  logic [3*color_width_o-1:0] vdata_i,
    input  logic [16:0]                vstep_i,
    input  logic [7:0]                 vphase_init_i,
    output logic                       HSYNC_o,
    output logic                       VSYNC_o,
    output logic                       DE_o,
    output logic [3*color_width_o-1:0] vdata_o,
    output logic [7:0]                 sl_rel_pos_o,
    output logic [10:0]                out_line_cnt_o,
    output logic [10:0]                in_line_cnt_o
);

    localparam int VW = 3*color_width_o;

    logic          hs_d1_q, hs_d1_d, hs_d2_q, hs_d2_d;
    logic          vs_d1_q, vs_d1_d, vs_d2_q, vs_d2_d;
    logic          de_d1_q, de_d1_d, de_d2_q, de_d2_d;
    logic [VW-1:0] vdata_d1_q, vdata_d1_d, vdata_d2_q, vdata_d2_d;
    logic [15:0]   acc_q, acc_d;
    logic [10:0]   out_cnt_q, out_cnt_d;
    logic [10:0]   in_cnt_q, in_cnt_d;
    logic          vs_pending_q, vs_pending_d;

    logic          hs_fall, vs_fall;
    logic [16:0]   stp;
    logic [16:0]   sum;

    always_comb begin
        hs_d1_d    = HSYNC_i;
        hs_d2_d    = hs_d1_q;
        vs_d1_d    = VSYNC_i;
        vs_d2_d    = vs_d1_q;
        de_d1_d    = DE_i;
        de_d2_d    = de_d1_q;
        vdata_d1_d = vdata_i;
        vdata_d2_d = vdata_d1_q;
    end

    // First stage holds the newest sample, second stage the previous one.
    assign hs_fall = !hs_d1_q && hs_d2_q;
    assign vs_fall = !vs_d1_q && vs_d2_q;

    always_comb begin
        stp = vstep_i;
        if (vstep_i < 17'h00100) begin
            stp = 17'h00100;
        end else if (vstep_i > 17'h10000) begin
            stp = 17'h10000;
        end
    end

    assign sum = {1'b0, acc_q} + stp;

    always_comb begin
        acc_d        = acc_q;
        out_cnt_d    = out_cnt_q;
        in_cnt_d     = in_cnt_q;
        vs_pending_d = vs_pending_q;
        if (hs_fall) begin
            vs_pending_d = 1'b0;
            if (vs_pending_q || vs_fall) begin
                acc_d     = {vphase_init_i, 8'h00};
                out_cnt_d = 11'd0;
                in_cnt_d  = 11'd0;
            end else begin
                acc_d = sum[15:0];
                if (out_cnt_q != 11'h7FF) begin
                    out_cnt_d = out_cnt_q + 11'd1;
                end
                if (sum[16] && in_cnt_q != 11'h7FF) begin
                    in_cnt_d = in_cnt_q + 11'd1;
                end
            end
        end else if (vs_fall) begin
            vs_pending_d = 1'b1;
        end
    end

    always_ff @(posedge VCLK_i or negedge nVRST_i) begin
        if (!nVRST_i) begin
            hs_d1_q      <= 1'b1;
            hs_d2_q      <= 1'b1;
            vs_d1_q      <= 1'b1;
            vs_d2_q      <= 1'b1;
            de_d1_q      <= 1'b0;
            de_d2_q      <= 1'b0;
            vdata_d1_q   <= '0;
            vdata_d2_q   <= '0;
            acc_q        <= 16'h0000;
            out_cnt_q    <= 11'd0;
            in_cnt_q     <= 11'd0;
            vs_pending_q <= 1'b1;
        end else begin
            hs_d1_q      <= hs_d1_d;
            hs_d2_q      <= hs_d2_d;
            vs_d1_q      <= vs_d1_d;
            vs_d2_q      <= vs_d2_d;
            de_d1_q      <= de_d1_d;
            de_d2_q      <= de_d2_d;
            vdata_d1_q   <= vdata_d1_d;
            vdata_d2_q   <= vdata_d2_d;
            acc_q        <= acc_d;
            out_cnt_q    <= out_cnt_d;
            in_cnt_q     <= in_cnt_d;
            vs_pending_q <= vs_pending_d;
        end
    end

    assign HSYNC_o        = hs_d2_q;
    assign VSYNC_o        = vs_d2_q;
    assign DE_o           = de_d2_q;
    assign vdata_o        = vdata_d2_q;
    assign sl_rel_pos_o   = acc_q[15:8];
    assign out_line_cnt_o = out_cnt_q;
    assign in_line_cnt_o  = in_cnt_q;

endmodule

// File: tb/tb_sl_vphase_gen.sv
// Bench for sl_vphase_gen: per-line position table plus a stream
// scoreboard checking the 2-cycle delay and position update alignment.
module tb_sl_vphase_gen;

    localparam int VW = 24;

    logic          clk;
    logic          rst_n;
    logic          hs_i, vs_i, de_i;
    logic [VW-1:0] vdata_i;
    logic [16:0]   vstep;
    logic [7:0]    vinit;
    logic          hs_o, vs_o, de_o;
    logic [VW-1:0] vdata_o;
    logic [7:0]    pos;
    logic [10:0]   ocnt, icnt;

    int n_chk  = 0;
    int n_fail = 0;

    sl_vphase_gen dut (
        .VCLK_i         (clk),
        .nVRST_i        (rst_n),
        .HSYNC_i        (hs_i),
        .VSYNC_i        (vs_i),
        .DE_i           (de_i),
        .vdata_i        (vdata_i),
        .vstep_i        (vstep),
        .vphase_init_i  (vinit),
        .HSYNC_o        (hs_o),
        .VSYNC_o        (vs_o),
        .DE_o           (de_o),
        .vdata_o        (vdata_o),
        .sl_rel_pos_o   (pos),
        .out_line_cnt_o (ocnt),
        .in_line_cnt_o  (icnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [2:0]    hs_vs_de;
        logic [VW-1:0] vdata;
    } smp_t;

    smp_t sb[$];
    logic mon_en = 1'b0;

    // Scoreboard: inputs pushed at the sampling edge, compared two edges on.
    initial begin
        smp_t s, e;
        logic first;
        logic [7:0] ppos;
        logic phs;
        first = 1'b1;
        ppos = '0;
        phs = 1'b1;
        forever begin
            @(posedge clk);
            if (mon_en) begin
                s.hs_vs_de = {hs_i, vs_i, de_i};
                s.vdata = vdata_i;
                sb.push_back(s);
            end
            @(negedge clk);
            if (!mon_en) begin
                first = 1'b1;
            end else begin
                if (sb.size() >= 2) begin
                    e = sb.pop_front();
                    chk("lat_hs", int'(hs_o), int'(e.hs_vs_de[2]));
                    chk("lat_vs", int'(vs_o), int'(e.hs_vs_de[1]));
                    chk("lat_de", int'(de_o), int'(e.hs_vs_de[0]));
                    chk("lat_vdata", int'(vdata_o), int'(e.vdata));
                end
                if (!first && pos != ppos) begin
                    chk("pos_vs_hsfall", int'({phs, hs_o}), 2);
                    chk("pos_in_de", int'(de_o), 0);
                end
                first = 1'b0;
                ppos = pos;
                phs = hs_o;
            end
        end
    end

    task automatic line(input logic vsf);
        if (vsf) begin
            vs_i = 1'b0;
            cyc(2);
            vs_i = 1'b1;
            cyc(1);
        end
        hs_i = 1'b0;
        cyc(2);
        hs_i = 1'b1;
        cyc(2);
        repeat (6) begin
            de_i = 1'b1;
            vdata_i = VW'($urandom);
            cyc(1);
        end
        de_i = 1'b0;
        vdata_i = VW'($urandom);
        cyc(3);
    endtask

    task automatic fast_line();
        hs_i = 1'b0;
        cyc(1);
        hs_i = 1'b1;
        cyc(3);
    endtask

    typedef struct {
        logic        vsf;
        logic [16:0] step;
        logic [7:0]  init;
        logic [7:0]  pos;
        logic [10:0] oc;
        logic [10:0] ic;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic v, input logic [16:0] s,
                       input logic [7:0] i, input logic [7:0] p,
                       input int o, input int c);
        vec_t r;
        r.vsf = v;
        r.step = s;
        r.init = i;
        r.pos = p;
        r.oc = 11'(o);
        r.ic = 11'(c);
        tbl.push_back(r);
    endtask

    initial begin
        rst_n = 1'b0;
        hs_i = 1'b1;
        vs_i = 1'b1;
        de_i = 1'b0;
        vdata_i = '0;
        vstep = 17'h10000;
        vinit = 8'h00;

        // 4x upscale
        add(1, 17'h04000, 8'h00, 8'h00, 0, 0);
        add(0, 17'h04000, 8'h00, 8'h40, 1, 0);
        add(0, 17'h04000, 8'h00, 8'h80, 2, 0);
        add(0, 17'h04000, 8'h00, 8'hC0, 3, 0);
        add(0, 17'h04000, 8'h00, 8'h00, 4, 1);
        add(0, 17'h04000, 8'h00, 8'h40, 5, 1);
        add(0, 17'h04000, 8'h00, 8'h80, 6, 1);
        add(0, 17'h04000, 8'h00, 8'hC0, 7, 1);
        // ~1.5x, init 0x80
        add(1, 17'h0AAAB, 8'h80, 8'h80, 0, 0);
        add(0, 17'h0AAAB, 8'h80, 8'h2A, 1, 1);
        add(0, 17'h0AAAB, 8'h80, 8'hD5, 2, 1);
        add(0, 17'h0AAAB, 8'h80, 8'h80, 3, 2);
        add(0, 17'h0AAAB, 8'h80, 8'h2A, 4, 3);
        // low clamp
        add(1, 17'h00050, 8'h10, 8'h10, 0, 0);
        add(0, 17'h00050, 8'h10, 8'h11, 1, 0);
        add(0, 17'h00050, 8'h10, 8'h12, 2, 0);
        add(0, 17'h000FF, 8'h10, 8'h13, 3, 0);
        add(0, 17'h00100, 8'h10, 8'h14, 4, 0);
        // high clamp
        add(1, 17'h1FFFF, 8'h33, 8'h33, 0, 0);
        add(0, 17'h1FFFF, 8'h33, 8'h33, 1, 1);
        add(0, 17'h1FFFF, 8'h33, 8'h33, 2, 2);
        add(0, 17'h10000, 8'h33, 8'h33, 3, 3);
        add(0, 17'h10001, 8'h33, 8'h33, 4, 4);

        cyc(3);
        chk("rst_hs", int'(hs_o), 1);
        chk("rst_vs", int'(vs_o), 1);
        chk("rst_de", int'(de_o), 0);
        chk("rst_vdata", int'(vdata_o), 0);
        chk("rst_pos", int'(pos), 0);
        chk("rst_ocnt", int'(ocnt), 0);
        chk("rst_icnt", int'(icnt), 0);
        rst_n = 1'b1;
        cyc(1);
        mon_en = 1'b1;
        cyc(2);

        foreach (tbl[i]) begin
            vstep = tbl[i].step;
            vinit = tbl[i].init;
            line(tbl[i].vsf);
            chk($sformatf("pos[%0d]", i), int'(pos), int'(tbl[i].pos));
            chk($sformatf("ocnt[%0d]", i), int'(ocnt), int'(tbl[i].oc));
            chk($sformatf("icnt[%0d]", i), int'(icnt), int'(tbl[i].ic));
        end

        // VS_fall and HS_fall in the same cycle
        vstep = 17'h04000;
        vinit = 8'h55;
        vs_i = 1'b0;
        hs_i = 1'b0;
        cyc(2);
        vs_i = 1'b1;
        hs_i = 1'b1;
        cyc(8);
        chk("sim_pos", int'(pos), 8'h55);
        chk("sim_ocnt", int'(ocnt), 0);
        chk("sim_icnt", int'(icnt), 0);
        line(1'b0);
        chk("sim_next_pos", int'(pos), 8'h95);
        chk("sim_next_ocnt", int'(ocnt), 1);
        chk("sim_next_icnt", int'(icnt), 0);

        // Asynchronous reset in the middle of an active line
        hs_i = 1'b0;
        cyc(2);
        hs_i = 1'b1;
        de_i = 1'b1;
        vs_i = 1'b0;
        vdata_i = 24'hA5A5A5;
        cyc(3);
        mon_en = 1'b0;
        sb.delete();
        rst_n = 1'b0;
        #1;
        chk("arst_hs", int'(hs_o), 1);
        chk("arst_vs", int'(vs_o), 1);
        chk("arst_de", int'(de_o), 0);
        chk("arst_vdata", int'(vdata_o), 0);
        chk("arst_pos", int'(pos), 0);
        chk("arst_ocnt", int'(ocnt), 0);
        chk("arst_icnt", int'(icnt), 0);
        cyc(2);
        de_i = 1'b0;
        vs_i = 1'b1;
        rst_n = 1'b1;
        cyc(1);
        mon_en = 1'b1;
        cyc(2);
        vinit = 8'h77;
        line(1'b0);
        chk("post_rst_pos", int'(pos), 8'h77);
        chk("post_rst_ocnt", int'(ocnt), 0);
        line(1'b0);
        chk("post_rst2_pos", int'(pos), 8'hB7);
        chk("post_rst2_ocnt", int'(ocnt), 1);

        // Counter saturation at the minimum HSYNC period
        vstep = 17'h10000;
        vinit = 8'h01;
        line(1'b1);
        repeat (2050) fast_line();
        chk("sat_ocnt", int'(ocnt), 2047);
        chk("sat_icnt", int'(icnt), 2047);
        chk("sat_pos", int'(pos), 8'h01);

        mon_en = 1'b0;
        cyc(2);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
